// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the unified memory between the CPU and a DMA port.
// Define ARB_RR_EN for round-robin ties; default build gives CPU priority.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic [1:0]    cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic [1:0]    dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic [1:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] lat_we;
  logic       any_req;
  logic       win;

  assign any_req = cpu_req | dma_req;

`ifdef ARB_RR_EN
  logic last;

  // a tie goes to the port that did not win the previous grant
  always_comb begin
    win = 1'b0;
    if (cpu_req && dma_req) win = ~last;
    else if (dma_req)       win = 1'b1;
    else                    win = 1'b0;
  end

  // last-owner pointer follows every grant; DMA after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     last <= 1'b1;
    else if (state == IDLE && any_req) last <= win;
  end
`else
  // the CPU wins every tie
  assign win = ~cpu_req;
`endif

  // grant, issue one command, wait out the latency, pulse the ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      owner     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= win;
            lat_we    <= win ? dma_we    : cpu_we;
            mem_we    <= win ? dma_we    : cpu_we;
            mem_addr  <= win ? dma_addr  : cpu_addr;
            mem_wdata <= win ? dma_wdata : cpu_wdata;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= '0;
          cnt    <= LAT;
          state  <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (lat_we == 2'b00) begin
              if (owner) dma_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
            if (owner) dma_ack <= 1'b1;
            else       cpu_ack <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          cpu_ack <= 1'b0;
          dma_ack <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LAT 2, 1 and 15.
// Each instance has its own latency-accurate memory response pipe.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, dma_req, lreq1, lreq2;
  logic [1:0]  cpu_we, dma_we;
  logic [31:0] cpu_addr, dma_addr;
  logic [63:0] cpu_wdata, dma_wdata;

  logic [63:0] c_rd [3];
  logic [63:0] d_rd [3];
  logic        c_ack [3];
  logic        d_ack [3];
  logic        own [3];
  logic        bsy [3];
  logic        men [3];
  logic [1:0]  mwe [3];
  logic [31:0] maddr [3];
  logic [63:0] mwd [3];
  logic [63:0] mrd [3];

  logic [63:0] mem [256];

  int nrun  = 0;
  int nfail = 0;

  mem_arbiter #(.AW(32), .DW(64), .MEM_LAT(2)) u0 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(c_rd[0]), .cpu_ack(c_ack[0]),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_rdata(d_rd[0]), .dma_ack(d_ack[0]),
    .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwd[0]), .mem_rdata(mrd[0]),
    .owner(own[0]), .busy(bsy[0])
  );

  mem_arbiter #(.AW(32), .DW(64), .MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset),
    .cpu_req(lreq1), .cpu_we(2'b00), .cpu_addr(cpu_addr),
    .cpu_wdata(64'h0), .cpu_rdata(c_rd[1]), .cpu_ack(c_ack[1]),
    .dma_req(1'b0), .dma_we(2'b00), .dma_addr(32'h0),
    .dma_wdata(64'h0), .dma_rdata(d_rd[1]), .dma_ack(d_ack[1]),
    .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwd[1]), .mem_rdata(mrd[1]),
    .owner(own[1]), .busy(bsy[1])
  );

  mem_arbiter #(.AW(32), .DW(64), .MEM_LAT(15)) u2 (
    .clk(clk), .reset(reset),
    .cpu_req(lreq2), .cpu_we(2'b00), .cpu_addr(cpu_addr),
    .cpu_wdata(64'h0), .cpu_rdata(c_rd[2]), .cpu_ack(c_ack[2]),
    .dma_req(1'b0), .dma_we(2'b00), .dma_addr(32'h0),
    .dma_wdata(64'h0), .dma_rdata(d_rd[2]), .dma_ack(d_ack[2]),
    .mem_en(men[2]), .mem_we(mwe[2]), .mem_addr(maddr[2]),
    .mem_wdata(mwd[2]), .mem_rdata(mrd[2]),
    .owner(own[2]), .busy(bsy[2])
  );

  // read data appears exactly L cycles after the mem_en cycle, junk otherwise
  for (genvar k = 0; k < 3; k++) begin : g_mem
    localparam int L = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    logic [15:0] v = '0;
    logic [31:0] a [16];
    always @(posedge clk) begin
      v    <= {v[14:0], men[k]};
      a[0] <= maddr[k];
      for (int i = 1; i < 16; i++) a[i] <= a[i-1];
    end
    assign mrd[k] = v[L-1] ? mem[a[L-1][9:2]] : 64'hDEAD_BEEF_0BAD_F00D;
  end

  always @(posedge clk)
    if (men[0] && mwe[0] != 2'b00) mem[maddr[0][9:2]] <= mwd[0];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) tick;
    nrun++;
    if ({men[0], mwe[0], own[0], bsy[0], c_ack[0], d_ack[0]} !== 7'b0) begin
      nfail++;
      $display("FAIL reset_ctrl: got %b%b%b%b%b%b want all zero",
               men[0], mwe[0], own[0], bsy[0], c_ack[0], d_ack[0]);
    end
    nrun++;
    if (maddr[0] !== 32'h0 || mwd[0] !== 64'h0) begin
      nfail++;
      $display("FAIL reset_cmd: addr %h wdata %h want 0", maddr[0], mwd[0]);
    end
    nrun++;
    if (c_rd[0] !== 64'h0 || d_rd[0] !== 64'h0) begin
      nfail++;
      $display("FAIL reset_rdata: cpu %h dma %h want 0", c_rd[0], d_rd[0]);
    end
    nrun++;
    if (bsy[1] !== 1'b0 || bsy[2] !== 1'b0) begin
      nfail++;
      $display("FAIL reset_busy_lat: %b %b want 0 0", bsy[1], bsy[2]);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_cpu_read;
    cpu_addr = 32'h40;
    cpu_we   = 2'b00;
    cpu_req  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 5) cpu_req = 1'b0;
      nrun++;
      if (men[0] !== (c == 1)) begin
        nfail++;
        $display("FAIL cpu_rd_en c%0d: got %b", c, men[0]);
      end
      nrun++;
      if (c_ack[0] !== (c == 4) || d_ack[0] !== 1'b0) begin
        nfail++;
        $display("FAIL cpu_rd_ack c%0d: cpu %b dma %b", c, c_ack[0], d_ack[0]);
      end
      nrun++;
      if (bsy[0] !== (c <= 4)) begin
        nfail++;
        $display("FAIL cpu_rd_busy c%0d: got %b", c, bsy[0]);
      end
      if (c == 1) begin
        nrun++;
        if (maddr[0] !== 32'h40 || mwe[0] !== 2'b00 || own[0] !== 1'b0) begin
          nfail++;
          $display("FAIL cpu_rd_cmd: addr %h we %b owner %b want 40 00 0",
                   maddr[0], mwe[0], own[0]);
        end
      end
      if (c == 4) begin
        nrun++;
        if (c_rd[0] !== 64'h1122334455667788) begin
          nfail++;
          $display("FAIL cpu_rd_data: got %h want 1122334455667788", c_rd[0]);
        end
      end
    end
  endtask

  task automatic test_dma_write;
    dma_addr  = 32'h80;
    dma_we    = 2'b01;
    dma_wdata = 64'hAB;
    dma_req   = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 5) dma_req = 1'b0;
      nrun++;
      if (men[0] !== (c == 1)) begin
        nfail++;
        $display("FAIL dma_wr_en c%0d: got %b", c, men[0]);
      end
      nrun++;
      if (d_ack[0] !== (c == 4) || c_ack[0] !== 1'b0) begin
        nfail++;
        $display("FAIL dma_wr_ack c%0d: dma %b cpu %b", c, d_ack[0], c_ack[0]);
      end
      if (c == 1) begin
        nrun++;
        if (mwe[0] !== 2'b01 || maddr[0] !== 32'h80 ||
            mwd[0] !== 64'hAB || own[0] !== 1'b1) begin
          nfail++;
          $display("FAIL dma_wr_cmd: we %b addr %h wdata %h owner %b",
                   mwe[0], maddr[0], mwd[0], own[0]);
        end
      end
      if (c == 4) begin
        nrun++;
        if (d_rd[0] !== 64'h0 || c_rd[0] !== 64'h1122334455667788) begin
          nfail++;
          $display("FAIL dma_wr_rdata: dma %h want 0, cpu %h want 1122334455667788",
                   d_rd[0], c_rd[0]);
        end
      end
    end
    nrun++;
    if (mem[32] !== 64'hAB) begin
      nfail++;
      $display("FAIL dma_wr_mem: got %h want ab", mem[32]);
    end
    dma_we = 2'b00;
  endtask

  task automatic test_arbitration;
    logic [4:0] exp_seq;
    int n      = 0;
    int last_c = -1;
`ifdef ARB_RR_EN
    exp_seq = 5'b11010;
`else
    exp_seq = 5'b10000;
`endif
    cpu_addr = 32'h40;
    dma_addr = 32'h80;
    cpu_req  = 1'b1;
    dma_req  = 1'b1;
    for (int c = 1; c <= 60 && n < 5; c++) begin
      tick;
      if (n == 4 && c == last_c + 1) cpu_req = 1'b0;
      if (c_ack[0] === 1'b1 || d_ack[0] === 1'b1) begin
        nrun++;
        if (d_ack[0] !== exp_seq[n] || c_ack[0] !== !exp_seq[n]) begin
          nfail++;
          $display("FAIL arb_order #%0d: cpu_ack %b dma_ack %b want dma=%b",
                   n, c_ack[0], d_ack[0], exp_seq[n]);
        end
        nrun++;
        if (d_ack[0] === 1'b1 ? (d_rd[0] !== 64'hAB)
                              : (c_rd[0] !== 64'h1122334455667788)) begin
          nfail++;
          $display("FAIL arb_data #%0d: cpu %h dma %h", n, c_rd[0], d_rd[0]);
        end
        if (n > 0) begin
          nrun++;
          if (c - last_c != 5) begin
            nfail++;
            $display("FAIL arb_gap #%0d: got %0d want 5", n, c - last_c);
          end
        end
        last_c = c;
        n++;
      end
    end
    nrun++;
    if (n != 5) begin
      nfail++;
      $display("FAIL arb_timeout: got %0d acks want 5", n);
    end
    tick;
    cpu_req = 1'b0;
    dma_req = 1'b0;
  endtask

  task automatic test_back_to_back;
    cpu_addr = 32'h40;
    cpu_req  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 5)  cpu_addr = 32'h44;
      if (c == 10) cpu_req  = 1'b0;
      nrun++;
      if (men[0] !== (c == 1 || c == 6)) begin
        nfail++;
        $display("FAIL b2b_en c%0d: got %b", c, men[0]);
      end
      nrun++;
      if (c_ack[0] !== (c == 4 || c == 9) || d_ack[0] !== 1'b0) begin
        nfail++;
        $display("FAIL b2b_ack c%0d: cpu %b dma %b", c, c_ack[0], d_ack[0]);
      end
      if (c == 6) begin
        nrun++;
        if (maddr[0] !== 32'h44) begin
          nfail++;
          $display("FAIL b2b_addr: got %h want 44", maddr[0]);
        end
      end
      if (c == 9) begin
        nrun++;
        if (c_rd[0] !== 64'h0102030405060708) begin
          nfail++;
          $display("FAIL b2b_data: got %h want 0102030405060708", c_rd[0]);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    cpu_addr = 32'h40;
    cpu_req  = 1'b1;
    tick;
    tick;
    #2;
    reset = 1'b0;
    #1;
    nrun++;
    if (bsy[0] !== 1'b0 || men[0] !== 1'b0 || own[0] !== 1'b0 ||
        maddr[0] !== 32'h0 || c_rd[0] !== 64'h0) begin
      nfail++;
      $display("FAIL rst_mid_async: busy %b en %b own %b addr %h rdata %h",
               bsy[0], men[0], own[0], maddr[0], c_rd[0]);
    end
    cpu_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      nrun++;
      if (c_ack[0] !== 1'b0 || bsy[0] !== 1'b0) begin
        nfail++;
        $display("FAIL rst_mid_hold c%0d: ack %b busy %b", c, c_ack[0], bsy[0]);
      end
    end
    reset = 1'b1;
    tick;
    cpu_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick;
      if (c == 5) cpu_req = 1'b0;
      nrun++;
      if (c_ack[0] !== (c == 4) || men[0] !== (c == 1)) begin
        nfail++;
        $display("FAIL rst_fresh c%0d: ack %b en %b", c, c_ack[0], men[0]);
      end
      if (c == 4) begin
        nrun++;
        if (c_rd[0] !== 64'h1122334455667788) begin
          nfail++;
          $display("FAIL rst_fresh_data: got %h want 1122334455667788", c_rd[0]);
        end
      end
    end
  endtask

  task automatic test_latency;
    cpu_addr = 32'h40;
    lreq1    = 1'b1;
    lreq2    = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick;
      if (c == 4)  lreq1 = 1'b0;
      if (c == 18) lreq2 = 1'b0;
      nrun++;
      if (c_ack[1] !== (c == 3)) begin
        nfail++;
        $display("FAIL lat1_ack c%0d: got %b", c, c_ack[1]);
      end
      nrun++;
      if (c_ack[2] !== (c == 17)) begin
        nfail++;
        $display("FAIL lat15_ack c%0d: got %b", c, c_ack[2]);
      end
      if (c == 3) begin
        nrun++;
        if (c_rd[1] !== 64'h1122334455667788) begin
          nfail++;
          $display("FAIL lat1_data: got %h", c_rd[1]);
        end
      end
      if (c == 17) begin
        nrun++;
        if (c_rd[2] !== 64'h1122334455667788) begin
          nfail++;
          $display("FAIL lat15_data: got %h", c_rd[2]);
        end
      end
    end
  endtask

  initial begin
    reset     = 1'b0;
    cpu_req   = 1'b0;
    dma_req   = 1'b0;
    lreq1     = 1'b0;
    lreq2     = 1'b0;
    cpu_we    = 2'b00;
    dma_we    = 2'b00;
    cpu_addr  = 32'h0;
    dma_addr  = 32'h0;
    cpu_wdata = 64'h0;
    dma_wdata = 64'h0;
    mem[16]   = 64'h1122334455667788;
    mem[17]   = 64'h0102030405060708;
    test_reset;
    test_cpu_read;
    test_dma_write;
    test_arbitration;
    test_back_to_back;
    test_reset_mid;
    test_latency;
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
